// File: rtl/abm_select_arbiter.sv
// abm_select_arbiter: owns select_s1 and hands the RAM's AXI slave between S0 and S1, draining bursts before each switch
module abm_select_arbiter #(
    parameter int CW       = 8,
    parameter int MAX_HOLD = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic req_s0,
    input  logic req_s1,
    input  logic m_awvalid,
    input  logic m_awready,
    input  logic m_bvalid,
    input  logic m_bready,
    input  logic m_arvalid,
    input  logic m_arready,
    input  logic m_rvalid,
    input  logic m_rready,
    input  logic m_rlast,
    output logic select_s1,
    output logic grant_s0,
    output logic grant_s1,
    output logic idle,
    output logic err
);
    localparam logic [2:0] SETTLE0 = 3'd0;
    localparam logic [2:0] OWN0    = 3'd1;
    localparam logic [2:0] DRAIN0  = 3'd2;
    localparam logic [2:0] SETTLE1 = 3'd3;
    localparam logic [2:0] OWN1    = 3'd4;
    localparam logic [2:0] DRAIN1  = 3'd5;
    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [31:0] HOLD_LAST = 32'(MAX_HOLD - 1);

    logic [2:0] state, state_nx;
    logic [CW-1:0] wr_out, rd_out, wr_nx, rd_nx;
    logic [31:0] hold_cnt, hold_inc, hold_nx;
    logic aw_hs, b_hs, ar_hs, r_hs, long_hold, quiet, err_nx;

    assign aw_hs     = m_awvalid & m_awready;
    assign b_hs      = m_bvalid & m_bready;
    assign ar_hs     = m_arvalid & m_arready;
    assign r_hs      = m_rvalid & m_rready & m_rlast;
    assign idle      = (wr_out == '0) && (rd_out == '0);
    assign long_hold = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LAST);
    assign quiet     = idle && !aw_hs && !ar_hs;
    assign hold_inc  = hold_cnt + {31'd0, hold_cnt != '1};

    // Simultaneous increment and decrement cancel, so neither can flag an error.
    always_comb begin
        wr_nx = (aw_hs && !b_hs && wr_out != CMAX) ? wr_out + 1'b1 :
                (b_hs && !aw_hs && wr_out != '0) ? wr_out - 1'b1 : wr_out;
        rd_nx = (ar_hs && !r_hs && rd_out != CMAX) ? rd_out + 1'b1 :
                (r_hs && !ar_hs && rd_out != '0) ? rd_out - 1'b1 : rd_out;
        err_nx = err
               | (aw_hs && !b_hs && wr_out == CMAX) | (b_hs && !aw_hs && wr_out == '0)
               | (ar_hs && !r_hs && rd_out == CMAX) | (r_hs && !ar_hs && rd_out == '0)
               | ((aw_hs || ar_hs) && state != OWN0 && state != OWN1);
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        case (state)
            SETTLE0: begin
                state_nx = OWN0;
                hold_nx  = '0;
            end
            OWN0: begin
                hold_nx  = req_s1 ? hold_inc : '0;
                state_nx = (req_s1 && (!req_s0 || long_hold)) ? DRAIN0 : OWN0;
            end
            DRAIN0:  state_nx = quiet ? SETTLE1 : DRAIN0;
            SETTLE1: begin
                state_nx = OWN1;
                hold_nx  = '0;
            end
            OWN1: begin
                hold_nx  = req_s0 ? hold_inc : '0;
                state_nx = (req_s0 && (!req_s1 || long_hold)) ? DRAIN1 : OWN1;
            end
            DRAIN1:  state_nx = quiet ? SETTLE0 : DRAIN1;
            default: state_nx = SETTLE0;
        endcase
    end

    // Outputs are registered from the next state so they carry no input-to-output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SETTLE0;
            select_s1 <= 1'b0;
            grant_s0  <= 1'b0;
            grant_s1  <= 1'b0;
            wr_out    <= '0;
            rd_out    <= '0;
            hold_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            select_s1 <= (state_nx == SETTLE1) || (state_nx == OWN1) || (state_nx == DRAIN1);
            grant_s0  <= state_nx == OWN0;
            grant_s1  <= state_nx == OWN1;
            wr_out    <= wr_nx;
            rd_out    <= rd_nx;
            hold_cnt  <= hold_nx;
            err       <= err_nx;
        end
    end
endmodule
